// File: rtl/level_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : level_ctrl
//  Brief    : Game-progress controller. Tracks vertical screen crossings per
//             frame, produces level, start handshake, finish flag, level-change
//             pulses and a freeze window for player repositioning.
//  Revision : 1.0 - initial release
// ============================================================================
module level_ctrl #(
  parameter int TOP_Y       = 16,
  parameter int BOTTOM_Y    = 752,
  parameter int FIN_X_MIN   = 500,
  parameter int FIN_X_MAX   = 700,
  parameter int FIN_Y_MIN   = 100,
  parameter int FIN_Y_MAX   = 112,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        start_btn,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  output logic [1:0]  level,
  output logic        started,
  output logic        level_up,
  output logic        level_down,
  output logic        freeze,
  output logic        finished
);

  localparam logic [11:0] C_TOP_Y     = 12'(TOP_Y);
  localparam logic [11:0] C_BOTTOM_Y  = 12'(BOTTOM_Y);
  localparam logic [11:0] C_FIN_X_MIN = 12'(FIN_X_MIN);
  localparam logic [11:0] C_FIN_X_MAX = 12'(FIN_X_MAX);
  localparam logic [11:0] C_FIN_Y_MIN = 12'(FIN_Y_MIN);
  localparam logic [11:0] C_FIN_Y_MAX = 12'(FIN_Y_MAX);
  localparam logic [3:0]  C_HOLD_LOAD = 4'(HOLD_FRAMES - 1);
  localparam logic [1:0]  C_LEVEL_MAX = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vblnk_d;
  logic        r_start_d;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [1:0]  r_level;
  logic [1:0]  w_level_nxt;
  logic        r_started;
  logic        w_started_nxt;
  logic        r_level_up;
  logic        w_level_up_nxt;
  logic        r_level_down;
  logic        w_level_down_nxt;
  logic        r_freeze;
  logic        w_freeze_nxt;
  logic        r_finished;
  logic        w_finished_nxt;

  logic        w_tick;
  logic        w_start_edge;
  logic        w_in_finish;
  logic        w_exit_top;
  logic        w_exit_bottom;

  assign w_tick        = vblnk & ~r_vblnk_d;
  assign w_start_edge  = start_btn & ~r_start_d;
  assign w_in_finish   = (x_value > C_FIN_X_MIN) && (x_value < C_FIN_X_MAX) &&
                         (y_value > C_FIN_Y_MIN) && (y_value < C_FIN_Y_MAX);
  assign w_exit_top    = (y_value < C_TOP_Y);
  assign w_exit_bottom = (y_value > C_BOTTOM_Y);

  always_comb begin
    w_state_nxt      = r_state;
    w_level_nxt      = r_level;
    w_cnt_nxt        = r_cnt;
    w_level_up_nxt   = 1'b0;
    w_level_down_nxt = 1'b0;
    w_finished_nxt   = r_finished;

    case (r_state)
      S_IDLE: begin
        w_level_nxt    = 2'd0;
        w_finished_nxt = 1'b0;
        // A tick coinciding with the start edge is consumed by the start only.
        if (w_start_edge) begin
          w_state_nxt = S_PLAY;
        end
      end

      S_PLAY: begin
        if (w_tick) begin
          if ((r_level == C_LEVEL_MAX) && w_in_finish) begin
            w_state_nxt    = S_DONE;
            w_finished_nxt = 1'b1;
          end else if (w_exit_top && (r_level != C_LEVEL_MAX)) begin
            w_level_nxt    = r_level + 2'd1;
            w_level_up_nxt = 1'b1;
            w_cnt_nxt      = C_HOLD_LOAD;
            w_state_nxt    = S_XFER;
          end else if (w_exit_bottom && (r_level != 2'd0)) begin
            w_level_nxt      = r_level - 2'd1;
            w_level_down_nxt = 1'b1;
            w_cnt_nxt        = C_HOLD_LOAD;
            w_state_nxt      = S_XFER;
          end
        end
      end

      S_XFER: begin
        // Counter starts at HOLD_FRAMES-1 so the window spans HOLD_FRAMES ticks.
        if (w_tick) begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = S_PLAY;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end

      S_DONE: begin
        if (w_start_edge) begin
          w_state_nxt    = S_IDLE;
          w_level_nxt    = 2'd0;
          w_finished_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_level_nxt    = 2'd0;
        w_finished_nxt = 1'b0;
      end
    endcase

    w_started_nxt = (w_state_nxt != S_IDLE);
    w_freeze_nxt  = (w_state_nxt == S_XFER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vblnk_d    <= 1'b0;
      r_start_d    <= 1'b0;
      r_cnt        <= 4'd0;
      r_level      <= 2'd0;
      r_started    <= 1'b0;
      r_level_up   <= 1'b0;
      r_level_down <= 1'b0;
      r_freeze     <= 1'b0;
      r_finished   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vblnk_d    <= vblnk;
      r_start_d    <= start_btn;
      r_cnt        <= w_cnt_nxt;
      r_level      <= w_level_nxt;
      r_started    <= w_started_nxt;
      r_level_up   <= w_level_up_nxt;
      r_level_down <= w_level_down_nxt;
      r_freeze     <= w_freeze_nxt;
      r_finished   <= w_finished_nxt;
    end
  end

  assign level      = r_level;
  assign started    = r_started;
  assign level_up   = r_level_up;
  assign level_down = r_level_down;
  assign freeze     = r_freeze;
  assign finished   = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_level_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_level_ctrl
//  Brief    : Directed self-checking bench for level_ctrl with a game-rule model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_level_ctrl;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic        vblnk;
  logic        start_btn;
  logic [11:0] x_value;
  logic [11:0] y_value;
  logic [1:0]  level;
  logic        started;
  logic        level_up;
  logic        level_down;
  logic        freeze;
  logic        finished;

  int n_checks = 0;
  int n_fail   = 0;

  level_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblnk      (vblnk),
    .start_btn  (start_btn),
    .x_value    (x_value),
    .y_value    (y_value),
    .level      (level),
    .started    (started),
    .level_up   (level_up),
    .level_down (level_down),
    .freeze     (freeze),
    .finished   (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game-rule model: a running/finished flag pair plus remaining hold ticks.
  bit m_started, m_finished, m_up, m_down;
  int m_level, m_hold;
  bit m_prev_v, m_prev_b;

  always @(posedge clk) begin
    bit tick, se;
    if (!rst_n) begin
      m_started = 0; m_finished = 0; m_up = 0; m_down = 0;
      m_level = 0; m_hold = 0; m_prev_v = 0; m_prev_b = 0;
    end else begin
      tick = vblnk && !m_prev_v;
      se   = start_btn && !m_prev_b;
      m_prev_v = vblnk;
      m_prev_b = start_btn;
      m_up = 0;
      m_down = 0;
      if (!m_started) begin
        if (se) m_started = 1;
      end else if (m_finished) begin
        if (se) begin
          m_started = 0; m_finished = 0; m_level = 0;
        end
      end else if (m_hold > 0) begin
        if (tick) m_hold--;
      end else if (tick) begin
        if (m_level == 3 && x_value > 500 && x_value < 700 && y_value > 100 && y_value < 112)
          m_finished = 1;
        else if (y_value < 16 && m_level < 3) begin
          m_level++; m_up = 1; m_hold = HOLD;
        end else if (y_value > 752 && m_level > 0) begin
          m_level--; m_down = 1; m_hold = HOLD;
        end
      end
    end
    #1;
    chk("model_level",      12'(level),      12'(m_level));
    chk("model_started",    12'(started),    12'(m_started));
    chk("model_level_up",   12'(level_up),   12'(m_up));
    chk("model_level_down", 12'(level_down), 12'(m_down));
    chk("model_freeze",     12'(freeze),     12'(m_hold > 0));
    chk("model_finished",   12'(finished),   12'(m_finished));
  end

  // One frame tick: vblnk high for one cycle; returns at the negedge after it.
  task automatic do_tick(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    x_value = x;
    y_value = y;
    vblnk   = 1'b1;
    @(negedge clk);
    vblnk   = 1'b0;
  endtask

  task automatic wait_hold();
    for (int i = 0; i < HOLD; i++) do_tick(12'd300, 12'd0);
  endtask

  task automatic press_start();
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vblnk = 1'b0; start_btn = 1'b0;
    x_value = 12'd300; y_value = 12'd300;

    // Reset held while vblnk toggles
    repeat (3) begin
      @(negedge clk);
      vblnk = ~vblnk;
    end
    @(negedge clk);
    vblnk = 1'b0;
    chk("reset_level",    12'(level), 12'd0);
    chk("reset_started",  12'(started), 12'd0);
    chk("reset_freeze",   12'(freeze), 12'd0);
    chk("reset_finished", 12'(finished), 12'd0);
    rst_n = 1'b1;

    press_start();
    chk("start_started", 12'(started), 12'd1);
    chk("start_level",   12'(level), 12'd0);

    // Climb 0 -> 1 and observe the freeze window length
    do_tick(12'd300, 12'd10);
    chk("up1_level",  12'(level), 12'd1);
    chk("up1_pulse",  12'(level_up), 12'd1);
    chk("up1_freeze", 12'(freeze), 12'd1);
    @(negedge clk);
    chk("up1_pulse_one_cycle", 12'(level_up), 12'd0);
    for (int i = 0; i < HOLD - 1; i++) do_tick(12'd300, 12'd0);
    chk("xfer_ignores_top", 12'(level), 12'd1);
    chk("freeze_before_last", 12'(freeze), 12'd1);
    do_tick(12'd300, 12'd0);
    chk("freeze_dropped", 12'(freeze), 12'd0);

    do_tick(12'd300, 12'd10);
    chk("up2_level", 12'(level), 12'd2);
    wait_hold();

    // Downward crossing, then saturation at 0
    do_tick(12'd300, 12'd760);
    chk("down_level", 12'(level), 12'd1);
    chk("down_pulse", 12'(level_down), 12'd1);
    wait_hold();
    do_tick(12'd300, 12'd760);
    wait_hold();
    chk("down_to_0", 12'(level), 12'd0);
    do_tick(12'd300, 12'd760);
    chk("sat0_level", 12'(level), 12'd0);
    chk("sat0_pulse", 12'(level_down), 12'd0);
    chk("sat0_freeze", 12'(freeze), 12'd0);

    // Climb to 3, then saturation at 3
    repeat (3) begin
      do_tick(12'd300, 12'd10);
      wait_hold();
    end
    chk("at3_level", 12'(level), 12'd3);
    do_tick(12'd300, 12'd5);
    chk("sat3_level", 12'(level), 12'd3);
    chk("sat3_pulse", 12'(level_up), 12'd0);

    // Finish box is exclusive on every edge
    do_tick(12'd500, 12'd105);
    chk("fin_xmin_edge", 12'(finished), 12'd0);
    do_tick(12'd700, 12'd105);
    chk("fin_xmax_edge", 12'(finished), 12'd0);
    do_tick(12'd600, 12'd112);
    chk("fin_ymax_edge", 12'(finished), 12'd0);
    do_tick(12'd600, 12'd105);
    chk("fin_hit", 12'(finished), 12'd1);
    chk("fin_started", 12'(started), 12'd1);
    chk("fin_level", 12'(level), 12'd3);
    do_tick(12'd600, 12'd900);
    chk("done_holds_level", 12'(level), 12'd3);

    // DONE -> IDLE on start
    press_start();
    chk("restart_level", 12'(level), 12'd0);
    chk("restart_finished", 12'(finished), 12'd0);
    chk("restart_started", 12'(started), 12'd0);

    // Start edge coincident with a tick, button then held for 10 cycles
    @(negedge clk);
    start_btn = 1'b1; vblnk = 1'b1; y_value = 12'd10;
    @(negedge clk);
    vblnk = 1'b0;
    chk("coinc_started", 12'(started), 12'd1);
    chk("coinc_level", 12'(level), 12'd0);
    chk("coinc_pulse", 12'(level_up), 12'd0);
    repeat (9) @(negedge clk);
    start_btn = 1'b0;
    chk("held_started", 12'(started), 12'd1);

    // Reset in the middle of a transfer
    do_tick(12'd300, 12'd10);
    do_tick(12'd300, 12'd0);
    chk("pre_rst_freeze", 12'(freeze), 12'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", 12'(level), 12'd0);
    chk("mid_rst_freeze", 12'(freeze), 12'd0);
    chk("mid_rst_started", 12'(started), 12'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/level_ctrl.md
Name: level_ctrl

Overview:
- Game-progress controller sitting directly upstream of the finish/start-screen overlay stage.
- Tracks the player's vertical screen crossings once per frame and produces the current level (0..3).
- Produces the start handshake (started, the overlay's sync input) and a latched game-finished flag.
- Issues one-cycle level-change pulses and a freeze window so the physics block can reposition the player between screens.

Parameters:
- TOP_Y, 16: y_value strictly below this at a frame tick means the player left through the top.
- BOTTOM_Y, 752: y_value strictly above this at a frame tick means the player fell through the bottom.
- FIN_X_MIN, 500: finish box left bound, exclusive.
- FIN_X_MAX, 700: finish box right bound, exclusive.
- FIN_Y_MIN, 100: finish box top bound, exclusive.
- FIN_Y_MAX, 112: finish box bottom bound, exclusive.
- HOLD_FRAMES, 4: number of frame ticks the freeze window lasts after a level change; range 1..15.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- vblnk  in  1  vertical blank from the VGA timing chain
- start_btn  in  1  debounced, already-synchronous start button
- x_value  in  12  player x, screen pixels
- y_value  in  12  player y, screen pixels
- level  out  2  current level
- started  out  1  game running; drives the overlay's sync input
- level_up  out  1  one-cycle pulse on an upward level change
- level_down  out  1  one-cycle pulse on a downward level change
- freeze  out  1  high during the transfer window; physics holds the player
- finished  out  1  finish reached; latched

Behaviour:
- Reset: all state is cleared when rst_n=0 at a clk edge.
  - State goes to IDLE.
  - level=0, started=0, level_up=0, level_down=0, freeze=0, finished=0.
  - Internal vblnk_d=0, start_d=0, frame counter=0.
  - Reset has priority over every other event, including reset asserted mid-transfer.
- Frame tick: tick = vblnk & ~vblnk_d, where vblnk_d is vblnk registered every cycle.
  - Every decision below is taken at the clk edge where tick=1.
  - The resulting outputs are visible on the next cycle (1-cycle latency from the vblnk rise).
- Start edge: start_edge = start_btn & ~start_d. It is evaluated every cycle and is not gated by tick.
- All output pulses are registered and last exactly one cycle.
- FSM states: IDLE, PLAY, XFER, DONE.
- IDLE:
  - level=0, started=0, freeze=0.
  - start_edge -> PLAY; started=1 from the next cycle.
- PLAY (evaluated on tick, in this priority order):
  1. level==3 and FIN_X_MIN<x_value<FIN_X_MAX and FIN_Y_MIN<y_value<FIN_Y_MAX -> DONE; finished=1.
  2. y_value<TOP_Y and level<3 -> level+1; level_up=1; -> XFER; counter loaded with HOLD_FRAMES-1.
  3. y_value>BOTTOM_Y and level>0 -> level-1; level_down=1; -> XFER; counter loaded with HOLD_FRAMES-1.
  4. Otherwise: no change.
  - Saturation: level 3 with y<TOP_Y, or level 0 with y>BOTTOM_Y, causes no change and no pulse.
- XFER:
  - freeze=1 from the cycle after entry.
  - y_value and x_value are ignored.
  - Each tick: if counter==0 -> PLAY with freeze=0 on the next cycle; else counter-1.
  - Result: exactly HOLD_FRAMES ticks elapse after the level-changing tick before freeze drops.
- DONE:
  - finished=1, started=1, level held, freeze=0.
  - start_edge -> IDLE with level=0, finished=0, started=0.
- start_edge is ignored in PLAY and XFER.
- A start_edge coincident with a tick in IDLE: go to PLAY only; that tick is not evaluated as gameplay.
- Widths:
  - All comparisons are unsigned 12-bit.
  - level arithmetic cannot wrap because of the saturation guards.
  - The counter is 4-bit.

Test Plan:
- Reset with rst_n=0 for 3 cycles while vblnk toggles -> all outputs 0, state IDLE; start_btn 0->1 -> started=1 one cycle later, level=0.
- PLAY, level=0, y_value=10, vblnk rises -> level=1 and level_up=1 for exactly one cycle, 1 cycle after the rise; freeze=1; freeze drops 1 cycle after the 4th subsequent tick.
- level=2, y_value=760 at a tick -> level=1, level_down pulse. Then level=0 with y_value=760 -> no change, no pulse. Then level=3 with y_value=5 -> stays 3, no pulse.
- level=3, x=600, y=105 at a tick -> finished=1. Then x=500, y=105 (boundary) from a fresh PLAY state -> no finish, because bounds are exclusive.
- XFER active with y_value=0 on every tick -> no further level change until freeze=0. Then rst_n=0 mid-XFER -> everything 0 the next cycle.
- DONE with start_btn pulsed -> IDLE, level=0, finished=0, started=0. start_btn held high for 10 cycles -> only one start_edge acted on.
